// File: rtl/frame_proc_scheduler.sv
// Frame-level sequencer for the camera pipeline: aligns work to VSYNC and the
// CCD-active level, then runs grayscale -> blob detection -> result publish,
// with frame decimation, per-stage timeouts, drop counting and overlay enable.
module frame_proc_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned DECIM          = 1,
    parameter int unsigned FRAME_CNT_W    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_vsync,
    input  logic                   i_ccd_valid,
    input  logic                   i_gray_done,
    input  logic                   i_blob_done,
    output logic                   o_gray_start,
    output logic                   o_gray_busy,
    output logic                   o_blob_start,
    output logic                   o_blob_busy,
    output logic                   o_result_latch,
    output logic                   o_overlay_en,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt,
    output logic [7:0]             o_drop_cnt,
    output logic                   o_timeout
);

    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned DECIM_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned DROP_W  = 8;

    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(DECIM - 1);
    localparam logic [DROP_W-1:0]  DROP_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FRAME = 3'd1,
        S_GRAY_RUN   = 3'd2,
        S_BLOB_ARM   = 3'd3,
        S_BLOB_RUN   = 3'd4,
        S_PUBLISH    = 3'd5
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   vsync_q;
    logic                   vs_edge;
    logic                   in_run;
    logic [DECIM_W-1:0]     decim_q;
    logic [DECIM_W-1:0]     decim_d;
    logic [TO_W-1:0]        to_cnt_q;
    logic [TO_W-1:0]        to_cnt_d;
    logic                   gray_start_d;
    logic                   gray_busy_d;
    logic                   blob_start_d;
    logic                   blob_busy_d;
    logic                   result_latch_d;
    logic                   overlay_en_d;
    logic                   timeout_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_d;
    logic [DROP_W-1:0]      drop_cnt_d;

    assign vs_edge = i_vsync & ~vsync_q;
    assign in_run  = (state_q == S_GRAY_RUN) || (state_q == S_BLOB_RUN);

    // Next-state, counter and output decode; disable overrides everything but reset.
    always_comb begin
        state_d        = state_q;
        decim_d        = decim_q;
        to_cnt_d       = to_cnt_q;
        gray_start_d   = 1'b0;
        blob_start_d   = 1'b0;
        result_latch_d = 1'b0;
        overlay_en_d   = o_overlay_en;
        timeout_d      = o_timeout;
        frame_cnt_d    = o_frame_cnt;
        drop_cnt_d     = o_drop_cnt;

        if (!i_enable) begin
            state_d      = S_IDLE;
            overlay_en_d = 1'b0;
            timeout_d    = 1'b0;
        end else begin
            if (vs_edge && in_run && (o_drop_cnt != DROP_MAX)) begin
                drop_cnt_d = o_drop_cnt + DROP_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT_FRAME;
                end
                S_WAIT_FRAME: begin
                    if (vs_edge && i_ccd_valid) begin
                        if (decim_q == '0) begin
                            state_d      = S_GRAY_RUN;
                            gray_start_d = 1'b1;
                            to_cnt_d     = '0;
                        end
                        decim_d = (decim_q == DECIM_LAST) ? '0 : decim_q + DECIM_W'(1);
                    end
                end
                S_GRAY_RUN: begin
                    if (i_gray_done) begin
                        state_d = S_BLOB_ARM;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d      = S_WAIT_FRAME;
                        timeout_d    = 1'b1;
                        overlay_en_d = 1'b0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                S_BLOB_ARM: begin
                    if (vs_edge) begin
                        state_d      = S_BLOB_RUN;
                        blob_start_d = 1'b1;
                        to_cnt_d     = '0;
                    end
                end
                S_BLOB_RUN: begin
                    if (i_blob_done) begin
                        state_d        = S_PUBLISH;
                        result_latch_d = 1'b1;
                        overlay_en_d   = 1'b1;
                        frame_cnt_d    = o_frame_cnt + FRAME_CNT_W'(1);
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d      = S_WAIT_FRAME;
                        timeout_d    = 1'b1;
                        overlay_en_d = 1'b0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                S_PUBLISH: begin
                    state_d = S_WAIT_FRAME;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        gray_busy_d = (state_d == S_GRAY_RUN);
        blob_busy_d = (state_d == S_BLOB_RUN);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Edge detector, stage counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vsync_q        <= 1'b0;
            decim_q        <= '0;
            to_cnt_q       <= '0;
            o_gray_start   <= 1'b0;
            o_gray_busy    <= 1'b0;
            o_blob_start   <= 1'b0;
            o_blob_busy    <= 1'b0;
            o_result_latch <= 1'b0;
            o_overlay_en   <= 1'b0;
            o_timeout      <= 1'b0;
            o_frame_cnt    <= '0;
            o_drop_cnt     <= '0;
        end else begin
            vsync_q        <= i_vsync;
            decim_q        <= decim_d;
            to_cnt_q       <= to_cnt_d;
            o_gray_start   <= gray_start_d;
            o_gray_busy    <= gray_busy_d;
            o_blob_start   <= blob_start_d;
            o_blob_busy    <= blob_busy_d;
            o_result_latch <= result_latch_d;
            o_overlay_en   <= overlay_en_d;
            o_timeout      <= timeout_d;
            o_frame_cnt    <= frame_cnt_d;
            o_drop_cnt     <= drop_cnt_d;
        end
    end

endmodule
